// File: rtl/fsm_seq_alarm_param.sv
// Programmable lamp-order detector with a timed alarm, repeat tolerance and illegal-input flag.
// Define FSM_ALARM_LATCH_EN for an alarm that latches until alarm_ack instead of timing out.
`timescale 1ns/1ps
module fsm_seq_alarm_param #(
    parameter int NUM_LAMPS  = 3,
    parameter int SEQ_LEN    = 3,
    parameter int ALARM_HOLD = 4,
    parameter int CNT_W      = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_LAMPS-1:0]                   lamps,
    input  logic                                   cfg_load,
    input  logic [SEQ_LEN*$clog2(NUM_LAMPS)-1:0]   seq_code,
    input  logic                                   alarm_ack,
    output logic                                   alarm_bit,
    output logic [$clog2(SEQ_LEN+1)-1:0]           progress,
    output logic                                   illegal,
    output logic [CNT_W-1:0]                       det_count
);
    localparam int IDX_W  = $clog2(NUM_LAMPS);
    localparam int PROG_W = $clog2(SEQ_LEN+1);
    localparam int LCNT_W = $clog2(NUM_LAMPS+1);

    typedef enum logic {T_IDLE, T_TRACK} track_t;
    typedef enum logic {A_OFF, A_ON} alarm_t;

    track_t              track_q, track_d;
    alarm_t              alarm_q, alarm_d;
    logic [PROG_W-1:0]   progress_q, progress_d;
    logic [IDX_W-1:0]    seq_q [SEQ_LEN];
    logic [CNT_W-1:0]    count_q, count_d;
    logic                illegal_q;
    logic [LCNT_W-1:0]   lamp_count;
    logic [IDX_W-1:0]    lamp_idx, cur_step, prev_step;
    logic                is_multi, detect;

`ifdef FSM_ALARM_LATCH_EN
`else
    localparam int HOLD_W = $clog2(ALARM_HOLD+1);
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                unused_ack;
    assign unused_ack = alarm_ack;
`endif

    always_comb begin
        lamp_count = '0;
        lamp_idx   = '0;
        for (int i = 0; i < NUM_LAMPS; i++) begin
            if (lamps[i]) begin
                lamp_count = lamp_count + 1'b1;
                lamp_idx   = IDX_W'(i);
            end
        end
        is_multi = (lamp_count > LCNT_W'(1));

        // Expected step and the step just matched (for repeat tolerance)
        cur_step  = seq_q[0];
        prev_step = seq_q[0];
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (progress_q == PROG_W'(k))   cur_step  = seq_q[k];
            if (progress_q == PROG_W'(k+1)) prev_step = seq_q[k];
        end

        progress_d = progress_q;
        detect     = 1'b0;
        if (cfg_load || is_multi) begin
            progress_d = '0;
        end else if (lamp_count != '0) begin
            if (lamp_idx == cur_step) begin
                if (progress_q == PROG_W'(SEQ_LEN-1)) begin
                    progress_d = '0;
                    detect     = 1'b1;
                end else begin
                    progress_d = progress_q + 1'b1;
                end
            end else if (!(track_q == T_TRACK && lamp_idx == prev_step)) begin
                progress_d = (lamp_idx == seq_q[0]) ? PROG_W'(1) : '0;
            end
        end
        track_d = (progress_d == '0) ? T_IDLE : T_TRACK;

        count_d = (detect && count_q != '1) ? count_q + 1'b1 : count_q;

        alarm_d = alarm_q;
`ifdef FSM_ALARM_LATCH_EN
        // A detection on the acknowledge cycle keeps the alarm raised
        if (detect)         alarm_d = A_ON;
        else if (alarm_ack) alarm_d = A_OFF;
`else
        hold_d = hold_q;
        if (detect) begin
            alarm_d = A_ON;
            hold_d  = HOLD_W'(ALARM_HOLD);
        end else if (alarm_q == A_ON) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HOLD_W'(1)) alarm_d = A_OFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            track_q    <= T_IDLE;
            alarm_q    <= A_OFF;
            progress_q <= '0;
            count_q    <= '0;
            illegal_q  <= 1'b0;
            for (int k = 0; k < SEQ_LEN; k++) seq_q[k] <= IDX_W'(k % NUM_LAMPS);
        end else begin
            track_q    <= track_d;
            alarm_q    <= alarm_d;
            progress_q <= progress_d;
            count_q    <= count_d;
            illegal_q  <= is_multi;
            if (cfg_load) begin
                for (int k = 0; k < SEQ_LEN; k++) seq_q[k] <= seq_code[k*IDX_W +: IDX_W];
            end
        end
    end

`ifdef FSM_ALARM_LATCH_EN
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`endif

    assign alarm_bit = (alarm_q == A_ON);
    assign progress  = progress_q;
    assign illegal   = illegal_q;
    assign det_count = count_q;
endmodule

// File: tb/tb_fsm_seq_alarm_param.sv
// Directed + randomized bench for fsm_seq_alarm_param against a behavioural model.
`timescale 1ns/1ps
module tb_fsm_seq_alarm_param;
    localparam int NUM_LAMPS  = 3;
    localparam int SEQ_LEN    = 3;
    localparam int ALARM_HOLD = 4;
    localparam int CNT_W      = 8;
    localparam int IDX_W      = $clog2(NUM_LAMPS);
    localparam int PROG_W     = $clog2(SEQ_LEN+1);

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_LAMPS-1:0]       lamps;
    logic                       cfg_load;
    logic [SEQ_LEN*IDX_W-1:0]   seq_code;
    logic                       alarm_ack;
    logic                       alarm_bit;
    logic [PROG_W-1:0]          progress;
    logic                       illegal;
    logic [CNT_W-1:0]           det_count;

    int checks = 0;
    int errors = 0;

    int m_prog, m_alarm_left, m_count;
    int m_seq [SEQ_LEN];
    bit m_latched, m_illegal;

    always #5 clk = ~clk;

    fsm_seq_alarm_param #(
        .NUM_LAMPS(NUM_LAMPS), .SEQ_LEN(SEQ_LEN), .ALARM_HOLD(ALARM_HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .lamps(lamps), .cfg_load(cfg_load), .seq_code(seq_code),
        .alarm_ack(alarm_ack), .alarm_bit(alarm_bit), .progress(progress),
        .illegal(illegal), .det_count(det_count)
    );

    function automatic int modelAlarm();
`ifdef FSM_ALARM_LATCH_EN
        return int'(m_latched);
`else
        return (m_alarm_left > 0) ? 1 : 0;
`endif
    endfunction

    task automatic modelReset();
        m_prog = 0; m_alarm_left = 0; m_count = 0; m_latched = 0; m_illegal = 0;
        for (int k = 0; k < SEQ_LEN; k++) m_seq[k] = k % NUM_LAMPS;
    endtask

    // One clock of the lamp-order rules, from the currently driven inputs
    task automatic modelStep();
        int ones, idx;
        bit det;
        ones = 0; idx = 0; det = 0;
        for (int i = 0; i < NUM_LAMPS; i++) if (lamps[i]) begin ones++; idx = i; end
        m_illegal = (ones > 1);
        if (cfg_load) begin
            for (int k = 0; k < SEQ_LEN; k++) m_seq[k] = (int'(seq_code) >> (k*IDX_W)) & ((1 << IDX_W) - 1);
            m_prog = 0;
        end else if (ones > 1) begin
            m_prog = 0;
        end else if (ones == 1) begin
            if (idx == m_seq[m_prog]) begin
                if (m_prog + 1 == SEQ_LEN) begin m_prog = 0; det = 1; end
                else m_prog++;
            end else if (m_prog > 0 && idx == m_seq[m_prog-1]) begin
                m_prog = m_prog;
            end else if (idx == m_seq[0]) m_prog = 1;
            else m_prog = 0;
        end
        if (det && m_count < (1 << CNT_W) - 1) m_count++;
        if (det) m_alarm_left = ALARM_HOLD;
        else if (m_alarm_left > 0) m_alarm_left--;
        if (det) m_latched = 1;
        else if (alarm_ack) m_latched = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".alarm"}, 32'(alarm_bit), 32'(modelAlarm()));
        check({tag, ".progress"}, 32'(progress), 32'(m_prog));
        check({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
        check({tag, ".det_count"}, 32'(det_count), 32'(m_count));
    endtask

    task automatic applyStimulus(input logic [NUM_LAMPS-1:0] l, input logic load,
                                 input logic [SEQ_LEN*IDX_W-1:0] code, input logic ack,
                                 input string tag);
        lamps = l; cfg_load = load; seq_code = code; alarm_ack = ack;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, '0, 1'b0, tag);
    endtask

    initial begin
        int high;
        logic [NUM_LAMPS-1:0] l;
        logic [SEQ_LEN*IDX_W-1:0] code;
        logic load;

        lamps = '0; cfg_load = 0; seq_code = '0; alarm_ack = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        check("reset.alarm", 32'(alarm_bit), 0);
        check("reset.progress", 32'(progress), 0);
        check("reset.illegal", 32'(illegal), 0);
        check("reset.det_count", 32'(det_count), 0);
        reset = 1'b1;

        // 1: basic detection and alarm length
        applyStimulus(3'b001, 0, '0, 0, "t1a");
        check("t1.prog1", 32'(progress), 1);
        applyStimulus(3'b010, 0, '0, 0, "t1b");
        check("t1.prog2", 32'(progress), 2);
        applyStimulus(3'b100, 0, '0, 0, "t1c");
        check("t1.prog0", 32'(progress), 0);
        check("t1.count", 32'(det_count), 1);
        high = int'(alarm_bit);
        for (int i = 0; i < 6; i++) begin
            applyStimulus('0, 0, '0, 0, "t1idle");
            high += int'(alarm_bit);
        end
`ifndef FSM_ALARM_LATCH_EN
        check("t1.alarm_cycles", 32'(high), ALARM_HOLD);
`endif

        // 2: repeats and gaps hold progress; stray lamp resets
        applyStimulus(3'b001, 0, '0, 0, "t2a");
        applyStimulus(3'b001, 0, '0, 0, "t2b");
        applyStimulus(3'b000, 0, '0, 0, "t2c");
        applyStimulus(3'b010, 0, '0, 0, "t2d");
        applyStimulus(3'b010, 0, '0, 0, "t2e");
        check("t2.repeat_hold", 32'(progress), 2);
        applyStimulus(3'b100, 0, '0, 0, "t2f");
        check("t2.count", 32'(det_count), 2);
        idle(6, "t2idle");
        applyStimulus(3'b001, 0, '0, 0, "t2g");
        applyStimulus(3'b100, 0, '0, 0, "t2h");
        check("t2.reset_prog", 32'(progress), 0);

        // 3: multiple lamps flag illegal
        applyStimulus(3'b001, 0, '0, 0, "t3a");
        applyStimulus(3'b010, 0, '0, 0, "t3b");
        applyStimulus(3'b011, 0, '0, 0, "t3c");
        check("t3.illegal", 32'(illegal), 1);
        applyStimulus(3'b010, 0, '0, 0, "t3d");
        check("t3.illegal_pulse", 32'(illegal), 0);
        applyStimulus(3'b100, 0, '0, 0, "t3e");
        check("t3.no_alarm", 32'(alarm_bit), 0);

        // 4: loaded order 0,2,1
        applyStimulus(3'b000, 1, 6'b01_10_00, 0, "t4load");
        applyStimulus(3'b001, 0, '0, 0, "t4a");
        applyStimulus(3'b100, 0, '0, 0, "t4b");
        applyStimulus(3'b010, 0, '0, 0, "t4c");
        check("t4.alarm", 32'(alarm_bit), 1);
        idle(6, "t4idle");
        applyStimulus(3'b001, 0, '0, 0, "t4d");
        applyStimulus(3'b010, 0, '0, 0, "t4e");
        applyStimulus(3'b100, 0, '0, 0, "t4f");
        check("t4.old_order", 32'(alarm_bit), 0);
        applyStimulus(3'b000, 1, 6'b10_01_00, 0, "t4restore");

        // 5: retrigger, saturation, async reset
        applyStimulus(3'b001, 0, '0, 0, "t5a");
        applyStimulus(3'b010, 0, '0, 0, "t5b");
        applyStimulus(3'b100, 0, '0, 0, "t5c");
        applyStimulus(3'b001, 0, '0, 0, "t5d");
        applyStimulus(3'b010, 0, '0, 0, "t5e");
        applyStimulus(3'b100, 0, '0, 0, "t5f");
        high = int'(alarm_bit);
        for (int i = 0; i < 6; i++) begin
            applyStimulus('0, 0, '0, 0, "t5idle");
            high += int'(alarm_bit);
        end
`ifndef FSM_ALARM_LATCH_EN
        check("t5.retrigger_cycles", 32'(high), ALARM_HOLD);
`endif
        for (int n = 0; n < 256; n++) begin
            applyStimulus(3'b001, 0, '0, 0, "t5sat");
            applyStimulus(3'b010, 0, '0, 0, "t5sat");
            applyStimulus(3'b100, 0, '0, 0, "t5sat");
        end
        check("t5.saturate", 32'(det_count), 255);
        check("t5.alarm_before_reset", 32'(alarm_bit), 1);
        reset = 1'b0;
        #2;
        check("t5.async_alarm", 32'(alarm_bit), 0);
        check("t5.async_count", 32'(det_count), 0);
        modelReset();
        @(posedge clk); #1;
        reset = 1'b1;

`ifdef FSM_ALARM_LATCH_EN
        // 6: latched alarm until acknowledged
        applyStimulus(3'b001, 0, '0, 0, "t6a");
        applyStimulus(3'b010, 0, '0, 0, "t6b");
        applyStimulus(3'b100, 0, '0, 0, "t6c");
        idle(20, "t6hold");
        check("t6.latched", 32'(alarm_bit), 1);
        applyStimulus(3'b000, 0, '0, 1, "t6ack");
        check("t6.acked", 32'(alarm_bit), 0);
`endif

        // Randomized traffic, biased toward one-hot lamps
        for (int n = 0; n < 800; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) l = '0;
            else if (r == 2) l = NUM_LAMPS'($urandom_range(3, 7));
            else l = NUM_LAMPS'(1 << $urandom_range(0, NUM_LAMPS-1));
            load = ($urandom_range(0, 39) == 0);
            code = ($urandom_range(0, 1) == 0) ? 6'b10_01_00 : SEQ_LEN*IDX_W'($urandom_range(0, 63));
            if (load) l = '0;
            applyStimulus(l, load, code, 1'($urandom_range(0, 7) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
